// File: rtl/sum_accumulator.sv
// Accumulates COUNT samples of {carry, sum} from a 4-bit adder into one
// ACC_W-bit windowed result. Define SUM_ACCUMULATOR_SATURATE_EN to clamp instead of wrap.
module sum_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic             accept_s;
    logic [ACC_W-1:0] base_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

    // One extra bit so the carry out of the accumulator is observable.
    function automatic logic [ACC_W:0] add_sample(input logic [ACC_W-1:0] base,
                                                  input logic [4:0]       smp);
        return {1'b0, base} + {{(ACC_W-4){1'b0}}, smp};
    endfunction

    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] sum);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        // Once clamped, every later add overflows again, so all-ones sticks.
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        return sum[ACC_W-1:0];
`endif
    endfunction

    // Next-value datapath; a window's first sample starts from zero.
    always_comb begin
        accept_s  = 1'b0;
        base_s    = '0;
        sum_s     = '0;
        acc_nxt_s = '0;
        cnt_nxt_s = '0;
        ovf_nxt_s = 1'b0;
        accept_s  = in_valid && (state_r != HOLD);
        if (state_r == IDLE) begin
            base_s    = '0;
            cnt_nxt_s = CNT_W'(1);
        end else begin
            base_s    = acc_r;
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
        sum_s     = add_sample(base_s, {in_carry, in_sum});
        acc_nxt_s = fold_sum(sum_s);
        ovf_nxt_s = ((state_r == IDLE) ? 1'b0 : ovf_r) | sum_s[ACC_W];
    end

    // Window FSM and result registers; clear outranks accept and handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_r <= acc_nxt_s;
                        cnt_r <= cnt_nxt_s;
                        ovf_r <= ovf_nxt_s;
                        if (cnt_nxt_s == CNT_LAST) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ACCUM;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Ready depends only on state; it is held low while reset is asserted.
    assign in_ready  = rst_n & (state_r != HOLD);
    assign out_valid = out_valid_r;
    assign out_acc   = acc_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an 8-bit/4-sample, a 6-bit/4-sample
// and an 8-bit/1-sample instance, with hand-computed expectations.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       c_valid;
    logic [3:0] in_sum;
    logic       in_carry;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_ovf;
    logic [7:0] a_out_acc;
    logic       b_in_ready, b_out_valid, b_out_ovf;
    logic [5:0] b_out_acc;
    logic       c_in_ready, c_out_valid, c_out_ovf;
    logic [7:0] c_out_acc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
        .out_ovf(a_out_ovf));

    sum_accumulator #(.ACC_W(6), .COUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
        .out_ovf(b_out_ovf));

    sum_accumulator #(.ACC_W(8), .COUNT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(c_valid),
        .in_ready(c_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_acc(c_out_acc),
        .out_ovf(c_out_ovf));

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    localparam int B_FULL_ACC = 63;
`else
    localparam int B_FULL_ACC = 60;
`endif

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic c);
        in_valid = v;
        in_sum   = s;
        in_carry = c;
    endtask

    initial begin
        int acc_hold;
        int results;
        rst_n = 1'b0; clear = 1'b0; c_valid = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        #12;
        check_eq("rst_in_ready", a_in_ready, 0);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_out_acc", a_out_acc, 0);
        check_eq("rst_out_ovf", a_out_ovf, 0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_in_ready", a_in_ready, 1);

        // Four samples of 31 back-to-back
        step();
        drive(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check_eq("w1_before_last_valid", a_out_valid, 0);
        check_eq("w1_running_acc", a_out_acc, 93);
        step();
        drive(1'b1, 4'd1, 1'b0);  // must be ignored while holding
        check_eq("w1_out_valid", a_out_valid, 1);
        check_eq("w1_out_acc", a_out_acc, 124);
        check_eq("w1_out_ovf", a_out_ovf, 0);
        check_eq("w1_b_out_acc", b_out_acc, B_FULL_ACC);
        check_eq("w1_b_out_ovf", b_out_ovf, 1);

        // Back-pressure for three cycles
        acc_hold = 124;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_out_valid", a_out_valid, 1);
            check_eq("hold_in_ready", a_in_ready, 0);
            check_eq("hold_out_acc", a_out_acc, acc_hold);
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_eq("handoff_out_valid", a_out_valid, 0);
        check_eq("handoff_in_ready", a_in_ready, 1);
        check_eq("handoff_acc_kept", a_out_acc, 124);

        // Partial window 5+7, gap, then clear discards it
        drive(1'b1, 4'd5, 1'b0);
        step();
        drive(1'b1, 4'd7, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_eq("partial_acc", a_out_acc, 12);
        step();
        check_eq("gap_acc_held", a_out_acc, 12);
        clear = 1'b1;
        drive(1'b1, 4'd9, 1'b0);
        step();
        clear = 1'b0;
        check_eq("clear_acc", a_out_acc, 0);
        check_eq("clear_out_valid", a_out_valid, 0);
        check_eq("clear_in_ready", a_in_ready, 1);
        drive(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("w2_no_valid", a_out_valid, 0);
        end
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_eq("w2_out_valid", a_out_valid, 1);
        check_eq("w2_out_acc", a_out_acc, 4);
        check_eq("w2_out_ovf", a_out_ovf, 0);
        check_eq("w2_b_out_acc", b_out_acc, 4);
        step();
        check_eq("w2_handoff", a_out_valid, 0);

        // Asynchronous reset mid-window after three samples of 2
        drive(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 4'd0, 1'b0);
        check_eq("pre_rst_acc", a_out_acc, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", a_out_valid, 0);
        check_eq("arst_out_acc", a_out_acc, 0);
        check_eq("arst_in_ready", a_in_ready, 0);
        rst_n = 1'b1;
        step();
        drive(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 4'd0, 1'b0);
        check_eq("w3_out_valid", a_out_valid, 1);
        check_eq("w3_out_acc", a_out_acc, 8);
        check_eq("w3_b_out_acc", b_out_acc, 8);
        step();
        check_eq("w3_handoff", a_out_valid, 0);

        // COUNT=1 instance streaming sample 3 with out_ready high
        in_sum = 4'd3;
        in_carry = 1'b0;
        c_valid = 1'b1;
        results = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (c_out_valid) results++;
            check_eq("c1_out_valid", c_out_valid, (i % 2 == 0) ? 1 : 0);
            check_eq("c1_in_ready", c_in_ready, (i % 2 == 0) ? 0 : 1);
            check_eq("c1_out_acc", c_out_acc, 3);
        end
        check_eq("c1_result_count", results, 3);
        c_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
